// File: rtl/spi_target_shifter.sv
// SPI mode-0 target shift engine.
// Consumes already-synchronized sclk/cs_n/mosi, assembles MSB-first receive
// words behind a valid/ready handshake and shifts transmit words out on miso.
module spi_target_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_load,
  output logic             busy,
  output logic             overrun,
  output logic             short_frame,
  input  logic             clear_flags
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Delayed copies of the synchronized inputs for edge detection.
  logic             sclk_reg;
  logic             cs_n_reg;
  // Set once cs_n has been seen high after reset; a frame already in
  // progress when reset is released must not look like a fresh cs_fall.
  logic             armed_reg;
  logic [CNT_W-1:0] bit_cnt_reg,  bit_cnt_next;
  // Only WIDTH-1 bits of receive history are ever needed: the newest bit
  // comes straight from mosi when a word completes.
  logic [WIDTH-2:0] rx_shift_reg, rx_shift_next;
  logic [WIDTH-1:0] tx_shift_reg, tx_shift_next;
  logic [WIDTH-1:0] rx_data_reg,  rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             overrun_reg,  overrun_next;
  logic             short_frame_reg, short_frame_next;

  logic             sclk_rise;
  logic             sclk_fall;
  logic             cs_fall;
  logic             cs_rise;
  logic             word_done;
  logic             consume;
  logic             tx_load_int;
  logic             overrun_set;
  logic             short_set;
  logic [WIDTH-1:0] rx_word;

  // sclk edges only count while the frame is active (registered cs_n low).
  assign sclk_rise   = sclk & ~sclk_reg & ~cs_n_reg;
  assign sclk_fall   = ~sclk & sclk_reg & ~cs_n_reg;
  assign cs_fall     = ~cs_n & cs_n_reg & armed_reg;
  assign cs_rise     = cs_n & ~cs_n_reg;
  assign word_done   = sclk_rise & (bit_cnt_reg == LAST_BIT);
  assign consume     = rx_valid_reg & rx_ready;
  assign rx_word     = {rx_shift_reg, mosi};
  // Reload the transmit shifter at frame start and on the falling edge that
  // follows each completed word.
  assign tx_load_int = ~rst & (cs_fall | (sclk_fall & (bit_cnt_reg == '0)));

  assign tx_load     = tx_load_int;
  assign busy        = ~cs_n_reg;
  assign miso_oe     = ~cs_n_reg;
  assign miso        = tx_shift_reg[WIDTH-1] & ~cs_n_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign overrun     = overrun_reg;
  assign short_frame = short_frame_reg;

  // Next-state logic for the shifters, bit counter, receive handshake and flags.
  always_comb begin
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    tx_shift_next = tx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = rx_valid_reg;
    overrun_set   = 1'b0;
    short_set     = 1'b0;

    if (sclk_rise) begin
      rx_shift_next = rx_word[WIDTH-2:0];
      bit_cnt_next  = (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CNT_ONE;
    end

    if (tx_load_int) begin
      tx_shift_next = tx_data;
    end else if (sclk_fall) begin
      tx_shift_next = {tx_shift_reg[WIDTH-2:0], 1'b0};
    end

    if (cs_fall) begin
      bit_cnt_next = '0;
    end

    // A word completing on the very cycle cs_n rises is not a short frame,
    // so the check looks at the count after this cycle's sclk edge.
    if (cs_rise) begin
      short_set     = (bit_cnt_next != '0);
      bit_cnt_next  = '0;
      rx_shift_next = '0;
    end

    if (word_done) begin
      rx_data_next  = rx_word;
      rx_valid_next = 1'b1;
      overrun_set   = rx_valid_reg & ~rx_ready;
    end else if (consume) begin
      rx_valid_next = 1'b0;
    end

    // Setting a sticky flag takes priority over clearing it.
    overrun_next     = (overrun_reg & ~clear_flags) | overrun_set;
    short_frame_next = (short_frame_reg & ~clear_flags) | short_set;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_reg        <= 1'b0;
      cs_n_reg        <= 1'b1;
      armed_reg       <= 1'b0;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      overrun_reg     <= 1'b0;
      short_frame_reg <= 1'b0;
    end else begin
      sclk_reg        <= sclk;
      cs_n_reg        <= cs_n | ~armed_reg;
      armed_reg       <= armed_reg | cs_n;
      bit_cnt_reg     <= bit_cnt_next;
      rx_shift_reg    <= rx_shift_next;
      tx_shift_reg    <= tx_shift_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      overrun_reg     <= overrun_next;
      short_frame_reg <= short_frame_next;
    end
  end

endmodule

// File: tb/tb_spi_target_shifter.sv
// Bench for spi_target_shifter: a bit-level SPI controller drives frames,
// expected receive words go into a scoreboard queue that a separate monitor
// drains on each rx handshake, and miso words are compared with the words
// the bench offered on tx_data.
module tb_spi_target_shifter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             busy;
  logic             overrun;
  logic             short_frame;
  logic             clear_flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_exp_q[$];     // expected receive words, in order
  logic [7:0] tx_loaded_q[$];  // every word offered on tx_data when a load happened
  logic [7:0] tx_plan_q[$];    // planned words for the next loads (else random)
  logic [7:0] fw [4];          // words of the frame being sent
  logic [7:0] got_w [4];       // words the controller sampled on miso
  int         half;            // sclk half period in clk cycles

  spi_target_shifter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .busy       (busy),
    .overrun    (overrun),
    .short_frame(short_frame),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted receive word is popped from the scoreboard.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        if (rx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got word 0x%02h, required no word", rx_data);
        end else begin
          exp = rx_exp_q.pop_front();
          check("rx_word", rx_data, exp);
          $display("rx word 0x%02h accepted (expected 0x%02h)", rx_data, exp);
        end
      end
    end
  end

  // Transmit source: record each word taken on a load, then offer the next.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_load) begin
        tx_loaded_q.push_back(tx_data);
        @(posedge clk);
        #1;
        if (tx_plan_q.size() > 0) tx_data = tx_plan_q.pop_front();
        else                      tx_data = 8'($urandom);
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  // One SPI mode-0 frame: nwords full words from fw[], then tail_bits of
  // fw[nwords]. Words with index >= push_from are expected on rx.
  task automatic send_frame(input int nwords, input int tail_bits, input int push_from,
                            input bit chk_latency, input bit ready_pulse_last);
    int         n0;
    int         total;
    int         bits;
    logic [7:0] w;
    n0    = tx_loaded_q.size();
    total = (tail_bits > 0) ? nwords + 1 : nwords;
    for (int i = push_from; i < nwords; i++) rx_exp_q.push_back(fw[i]);
    w    = fw[0];
    mosi = w[7];
    cs_n = 1'b0;
    @(negedge clk);
    check("tx_load_at_cs_fall", tx_load, 1'b1);
    tick(half);
    check("busy_in_frame", busy, 1'b1);
    check("miso_oe_in_frame", miso_oe, 1'b1);
    for (int wi = 0; wi < total; wi++) begin
      bits = (wi < nwords) ? 8 : tail_bits;
      w    = fw[wi];
      for (int b = 0; b < bits; b++) begin
        mosi = w[7-b];
        sclk = 1'b1;
        got_w[wi][7-b] = miso;
        if (wi == nwords - 1 && b == 7 && chk_latency) begin
          @(negedge clk);
          check("rx_valid_before_edge", rx_valid, 1'b0);
          @(negedge clk);
          check("rx_valid_latency", rx_valid, 1'b1);
          check("rx_data_latency", rx_data, fw[wi]);
          @(posedge clk);
          #1;
          tick(half - 2);
        end else if (wi == nwords - 1 && b == 7 && ready_pulse_last) begin
          rx_ready = 1'b1;
          tick(1);
          rx_ready = 1'b0;
          tick(half - 1);
        end else begin
          tick(half);
        end
        sclk = 1'b0;
        tick(half);
      end
    end
    cs_n = 1'b1;
    tick(2);
    check("busy_after_frame", busy, 1'b0);
    check("tx_load_count", tx_loaded_q.size() - n0, nwords + 1);
    for (int wi = 0; wi < nwords; wi++) begin
      if (n0 + wi < tx_loaded_q.size()) begin
        check("miso_word", got_w[wi], tx_loaded_q[n0 + wi]);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL miso_word: got no load for word %0d, required one", wi);
      end
    end
    $display("frame: %0d words, %0d tail bits, half=%0d", nwords, tail_bits, half);
  endtask

  initial begin
    int n0;
    int seen;
    rst         = 1'b1;
    sclk        = 1'b0;
    cs_n        = 1'b1;
    mosi        = 1'b0;
    rx_ready    = 1'b1;
    clear_flags = 1'b0;
    tx_data     = 8'h00;
    half        = 4;

    // Reset state.
    tick(3);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_load", tx_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_short_frame", short_frame, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(3);

    // Single word, sclk = clk/8.
    tx_data = 8'hA5;
    fw[0]   = 8'h3C;
    send_frame(1, 0, 0, 1'b1, 1'b0);
    check("single_miso", got_w[0], 8'hA5);

    // Back-to-back words in one frame.
    tx_data = 8'h55;
    tx_plan_q.push_back(8'hAA);
    fw[0] = 8'h01;
    fw[1] = 8'hFF;
    send_frame(2, 0, 0, 1'b0, 1'b0);
    check("b2b_miso0", got_w[0], 8'h55);
    check("b2b_miso1", got_w[1], 8'hAA);

    // Overrun: nobody consumes, second word overwrites the first.
    rx_ready = 1'b0;
    fw[0] = 8'h11;
    fw[1] = 8'h22;
    send_frame(2, 0, 1, 1'b0, 1'b0);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rx_valid", rx_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    check("ovr_valid_kept", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_valid_consumed", rx_valid, 1'b0);

    // Completion and consume in the same cycle.
    rx_ready = 1'b0;
    fw[0] = 8'h11;
    fw[1] = 8'h22;
    send_frame(2, 0, 0, 1'b0, 1'b1);
    check("sim_rx_data", rx_data, 8'h22);
    check("sim_rx_valid", rx_valid, 1'b1);
    check("sim_no_overrun", overrun, 1'b0);
    rx_ready = 1'b1;
    tick(2);
    check("sim_valid_consumed", rx_valid, 1'b0);

    // Short frame: 5 bits of 0xF0, then a full frame.
    fw[0] = 8'hF0;
    send_frame(0, 5, 0, 1'b0, 1'b0);
    check("short_flag", short_frame, 1'b1);
    check("short_rx_valid", rx_valid, 1'b0);
    check("short_rx_data", rx_data, 8'h22);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("short_cleared", short_frame, 1'b0);
    fw[0] = 8'h81;
    send_frame(1, 0, 0, 1'b0, 1'b0);
    check("after_short_rx_data", rx_data, 8'h81);
    check("after_short_flag", short_frame, 1'b0);

    // Reset mid-frame after 3 bits.
    mosi = 1'b1;
    cs_n = 1'b0;
    tick(half);
    repeat (3) begin
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      tick(half);
    end
    rst = 1'b1;
    tick(1);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_miso", miso, 1'b0);
    check("mid_rst_miso_oe", miso_oe, 1'b0);
    check("mid_rst_tx_load", tx_load, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_short", short_frame, 1'b0);
    rst  = 1'b0;
    n0   = tx_loaded_q.size();
    seen = 0;
    repeat (16) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      repeat (half) begin
        @(negedge clk);
        if (rx_valid) seen++;
        @(posedge clk);
        #1;
      end
    end
    sclk = 1'b0;
    tick(half);
    check("ignored_frame_rx_valid", seen, 0);
    check("ignored_frame_busy", busy, 1'b0);
    check("ignored_frame_loads", tx_loaded_q.size() - n0, 0);
    cs_n = 1'b1;
    tick(3);
    fw[0] = 8'($urandom);
    send_frame(1, 0, 0, 1'b0, 1'b0);
    check("resync_rx_data", rx_data, fw[0]);

    // Randomized frames at varying sclk rates.
    for (int f = 0; f < 12; f++) begin
      int nw;
      half = $urandom_range(2, 5);
      nw   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) fw[i] = 8'($urandom);
      send_frame(nw, 0, 0, 1'b0, 1'b0);
      tick($urandom_range(1, 4));
    end
    check("rand_no_overrun", overrun, 1'b0);
    check("rand_no_short", short_frame, 1'b0);

    tick(4);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
